rob_param: RTL

Parametrised reorder buffer for the out-of-order RV32I core. It replaces the fixed `SIZE_ROB`-entry, single-CDB arrangement with configurable depth and CDB channel count. It allocates in-order IDs at dispatch, captures results from `NUM_CDB` common data bus channels, and retires in program order one entry per cycle. It also generates a per-ID flush mask and a redirect PC when a mispredicted branch reaches the head.

---
 rtl/rob_param.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocation, multi-channel CDB completion,
// in-order retirement, and flush generation when a mispredicted branch retires.
module rob_param #(
    parameter int DEPTH   = 8,
    parameter int NUM_CDB = 2,
    localparam int IDW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alloc_valid,
    input  logic [4:0]             alloc_rd,
    input  logic                   alloc_is_br,
    input  logic                   alloc_is_store,
    output logic                   alloc_ready,
    output logic [IDW-1:0]         alloc_id,
    input  logic [NUM_CDB-1:0]     cdb_valid,
    input  logic [NUM_CDB*IDW-1:0] cdb_id,
    input  logic [NUM_CDB*32-1:0]  cdb_data,
    input  logic [NUM_CDB-1:0]     cdb_mispred,
    input  logic [NUM_CDB*32-1:0]  cdb_target,
    input  logic [IDW-1:0]         rd_id_a,
    input  logic [IDW-1:0]         rd_id_b,
    output logic                   rd_done_a,
    output logic                   rd_done_b,
    output logic [31:0]            rd_data_a,
    output logic [31:0]            rd_data_b,
    output logic                   commit_valid,
    input  logic                   commit_ready,
    output logic [IDW-1:0]         commit_id,
    output logic [4:0]             commit_rd,
    output logic [31:0]            commit_data,
    output logic                   commit_is_store,
    output logic                   flush_en,
    output logic [31:0]            flush_pc,
    output logic [DEPTH-1:0]       flush_mask
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] mispred_q;
    logic [DEPTH-1:0] is_br_q;
    logic [DEPTH-1:0] is_store_q;
    logic [4:0]       rd_q     [DEPTH];
    logic [31:0]      data_q   [DEPTH];
    logic [31:0]      target_q [DEPTH];

    logic [IDW-1:0]   head_q;
    logic [IDW-1:0]   tail_q;
    logic [IDW:0]     count_q;

    logic [IDW-1:0]   ch_id     [NUM_CDB];
    logic [31:0]      ch_data   [NUM_CDB];
    logic [31:0]      ch_target [NUM_CDB];
    logic [NUM_CDB-1:0] ch_hit;

    logic             alloc_fire;
    logic             commit_fire;
    logic             flush_now;
    logic [DEPTH-1:0] head_oh;

    always_comb begin
        for (int c = 0; c < NUM_CDB; c++) begin
            ch_id[c]     = cdb_id[c*IDW +: IDW];
            ch_data[c]   = cdb_data[c*32 +: 32];
            ch_target[c] = cdb_target[c*32 +: 32];
            ch_hit[c]    = cdb_valid[c] && valid_q[ch_id[c]];
        end
    end

    assign commit_valid    = valid_q[head_q] && done_q[head_q];
    assign commit_id       = head_q;
    assign commit_rd       = rd_q[head_q];
    assign commit_data     = data_q[head_q];
    assign commit_is_store = is_store_q[head_q];
    assign commit_fire     = commit_valid && commit_ready;
    assign flush_now       = commit_fire && is_br_q[head_q] && mispred_q[head_q];

    // Space freed by a same-cycle commit is only visible from the next cycle.
    assign alloc_ready = (count_q < (IDW+1)'(DEPTH)) && !flush_now;
    assign alloc_id    = tail_q;
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign head_oh     = {{(DEPTH-1){1'b0}}, 1'b1} << head_q;

    assign rd_done_a = valid_q[rd_id_a] && done_q[rd_id_a];
    assign rd_done_b = valid_q[rd_id_b] && done_q[rd_id_b];
    assign rd_data_a = data_q[rd_id_a];
    assign rd_data_b = data_q[rd_id_b];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q    <= '0;
            done_q     <= '0;
            mispred_q  <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            flush_en   <= 1'b0;
            flush_mask <= '0;
            flush_pc   <= '0;
        end else begin
            flush_en <= flush_now;
            if (flush_now) begin
                flush_mask <= valid_q & ~head_oh;
                flush_pc   <= target_q[head_q];
            end
            // Descending scan so the lowest channel's write lands last and wins.
            for (int c = NUM_CDB-1; c >= 0; c--) begin
                if (ch_hit[c]) begin
                    done_q[ch_id[c]]    <= 1'b1;
                    mispred_q[ch_id[c]] <= cdb_mispred[c];
                end
            end
            if (alloc_fire) begin
                valid_q[tail_q]   <= 1'b1;
                done_q[tail_q]    <= 1'b0;
                mispred_q[tail_q] <= 1'b0;
                tail_q            <= tail_q + 1'b1;
            end
            if (commit_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (flush_now) begin
                valid_q <= '0;
                head_q  <= head_q + 1'b1;
                tail_q  <= head_q + 1'b1;
                count_q <= '0;
            end else begin
                count_q <= count_q + {{IDW{1'b0}}, alloc_fire} - {{IDW{1'b0}}, commit_fire};
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = NUM_CDB-1; c >= 0; c--) begin
            if (ch_hit[c]) begin
                data_q[ch_id[c]]   <= ch_data[c];
                target_q[ch_id[c]] <= ch_target[c];
            end
        end
        if (alloc_fire) begin
            rd_q[tail_q]       <= alloc_rd;
            is_br_q[tail_q]    <= alloc_is_br;
            is_store_q[tail_q] <= alloc_is_store;
        end
    end

endmodule
